// File: rtl/axi_pkg.sv
// Shared AXI4 definitions: response/burst codes, master FSM states,
// and the AxSIZE helper.
package axi_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WADDR = 3'd1,
    ST_WDATA = 3'd2,
    ST_WRESP = 3'd3,
    ST_RADDR = 3'd4,
    ST_RDATA = 3'd5,
    ST_DONE  = 3'd6
  } mst_state_e;

  function automatic logic [2:0] size_of(input int dw);
    case (dw)
      8:       size_of = 3'd0;
      16:      size_of = 3'd1;
      32:      size_of = 3'd2;
      64:      size_of = 3'd3;
      default: size_of = 3'd2;
    endcase
  endfunction

endpackage

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 master: turns a command plus write/read
// beat streams into INCR bursts, reporting completion on a done pulse.
module axi_burst_master
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter logic [ID_WIDTH-1:0] MASTER_ID = '0
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  output logic                    done,
  output logic [1:0]              done_resp,
  output logic                    done_err,
  output logic [ID_WIDTH-1:0]     M_AXI_awid,
  output logic [ADDR_WIDTH-1:0]   M_AXI_awaddr,
  output logic [7:0]              M_AXI_awlen,
  output logic [2:0]              M_AXI_awsize,
  output logic [1:0]              M_AXI_awburst,
  output logic [1:0]              M_AXI_awlock,
  output logic [3:0]              M_AXI_awcache,
  output logic [2:0]              M_AXI_awprot,
  output logic [3:0]              M_AXI_awqos,
  output logic [3:0]              M_AXI_awregion,
  output logic                    M_AXI_awvalid,
  input  logic                    M_AXI_awready,
  output logic [DATA_WIDTH-1:0]   M_AXI_wdata,
  output logic [DATA_WIDTH/8-1:0] M_AXI_wstrb,
  output logic                    M_AXI_wlast,
  output logic                    M_AXI_wvalid,
  input  logic                    M_AXI_wready,
  input  logic [ID_WIDTH-1:0]     M_AXI_bid,
  input  logic [1:0]              M_AXI_bresp,
  input  logic                    M_AXI_bvalid,
  output logic                    M_AXI_bready,
  output logic [ID_WIDTH-1:0]     M_AXI_arid,
  output logic [ADDR_WIDTH-1:0]   M_AXI_araddr,
  output logic [7:0]              M_AXI_arlen,
  output logic [2:0]              M_AXI_arsize,
  output logic [1:0]              M_AXI_arburst,
  output logic [1:0]              M_AXI_arlock,
  output logic [3:0]              M_AXI_arcache,
  output logic [2:0]              M_AXI_arprot,
  output logic [3:0]              M_AXI_arqos,
  output logic [3:0]              M_AXI_arregion,
  output logic                    M_AXI_arvalid,
  input  logic                    M_AXI_arready,
  input  logic [ID_WIDTH-1:0]     M_AXI_rid,
  input  logic [DATA_WIDTH-1:0]   M_AXI_rdata,
  input  logic [1:0]              M_AXI_rresp,
  input  logic                    M_AXI_rlast,
  input  logic                    M_AXI_rvalid,
  output logic                    M_AXI_rready
);

  mst_state_e state, state_next;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            beat_cnt;
  logic                  err_q;
  logic [1:0]            resp_q;

  logic last_beat;
  logic w_hs;
  logic r_hs;

  assign last_beat = (beat_cnt == len_q);
  assign w_hs = (state == ST_WDATA) && wr_valid && M_AXI_wready;
  assign r_hs = (state == ST_RDATA) && M_AXI_rvalid;

  assign M_AXI_awid     = MASTER_ID;
  assign M_AXI_awaddr   = addr_q;
  assign M_AXI_awlen    = len_q;
  assign M_AXI_awsize   = size_of(DATA_WIDTH);
  assign M_AXI_awburst  = BURST_INCR;
  assign M_AXI_awlock   = 2'b00;
  assign M_AXI_awcache  = 4'b0011;
  assign M_AXI_awprot   = 3'b000;
  assign M_AXI_awqos    = 4'b0000;
  assign M_AXI_awregion = 4'b0000;

  assign M_AXI_arid     = MASTER_ID;
  assign M_AXI_araddr   = addr_q;
  assign M_AXI_arlen    = len_q;
  assign M_AXI_arsize   = size_of(DATA_WIDTH);
  assign M_AXI_arburst  = BURST_INCR;
  assign M_AXI_arlock   = 2'b00;
  assign M_AXI_arcache  = 4'b0011;
  assign M_AXI_arprot   = 3'b000;
  assign M_AXI_arqos    = 4'b0000;
  assign M_AXI_arregion = 4'b0000;

  // Write data is a straight passthrough so beats can stream back to back.
  assign M_AXI_wdata = wr_data;
  assign M_AXI_wstrb = wr_strb;
  assign done_resp   = resp_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    cmd_ready     = 1'b0;
    M_AXI_awvalid = 1'b0;
    M_AXI_wvalid  = 1'b0;
    M_AXI_wlast   = 1'b0;
    wr_ready      = 1'b0;
    M_AXI_bready  = 1'b0;
    M_AXI_arvalid = 1'b0;
    M_AXI_rready  = 1'b0;
    done          = 1'b0;
    done_err      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid)
          state_next = cmd_write ? ST_WADDR : ST_RADDR;
      end
      ST_WADDR: begin
        M_AXI_awvalid = 1'b1;
        if (M_AXI_awready) state_next = ST_WDATA;
      end
      ST_WDATA: begin
        M_AXI_wvalid = wr_valid;
        M_AXI_wlast  = last_beat;
        wr_ready     = M_AXI_wready;
        if (w_hs && last_beat) state_next = ST_WRESP;
      end
      ST_WRESP: begin
        M_AXI_bready = 1'b1;
        if (M_AXI_bvalid) state_next = ST_DONE;
      end
      ST_RADDR: begin
        M_AXI_arvalid = 1'b1;
        if (M_AXI_arready) state_next = ST_RDATA;
      end
      ST_RDATA: begin
        M_AXI_rready = 1'b1;
        if (r_hs && last_beat) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        done_err   = err_q;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      addr_q   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
      resp_q   <= RESP_OKAY;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= r_hs;
      if (state == ST_IDLE && cmd_valid) begin
        addr_q   <= cmd_addr;
        len_q    <= cmd_len;
        beat_cnt <= '0;
        err_q    <= 1'b0;
        resp_q   <= RESP_OKAY;
      end
      if (w_hs) beat_cnt <= beat_cnt + 8'd1;
      if (state == ST_WRESP && M_AXI_bvalid) begin
        resp_q <= M_AXI_bresp;
        if (M_AXI_bid != MASTER_ID) err_q <= 1'b1;
      end
      // Read exit follows the internal count; rlast is only cross-checked.
      if (r_hs) begin
        beat_cnt <= beat_cnt + 8'd1;
        rd_data  <= M_AXI_rdata;
        rd_last  <= last_beat;
        if (M_AXI_rresp > resp_q) resp_q <= M_AXI_rresp;
        if ((M_AXI_rlast != last_beat) || (M_AXI_rid != MASTER_ID))
          err_q <= 1'b1;
      end
    end
  end

endmodule
